// File: rtl/mac_acc.sv
// Accumulates COLUMN signed partial-sum lanes over a first..last group and queues
// finished, per-lane saturated results in a 2-entry FIFO for writeback.
module mac_acc #(
    parameter int COLUMN = 6,
    parameter int OW     = 22,
    parameter int AW     = 32,
    parameter int RELU   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLUMN*OW-1:0]  s_data,
    input  logic                  s_first,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [COLUMN*AW-1:0]  m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [15:0]           grp_beats,
    output logic                  err
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t                state, state_nxt;
    logic [COLUMN*AW-1:0]  acc;
    logic [15:0]           cnt, cnt_nxt;
    logic [COLUMN*AW-1:0]  sum_vec, push_vec;
    logic [COLUMN*AW-1:0]  fifo_data [2];
    logic [15:0]           fifo_beats [2];
    logic [1:0]            fifo_count;
    logic                  wr_ptr, rd_ptr;
    logic                  accept, push, pop, restart, proto_err;
    logic [AW-1:0]         base, sat;
    logic [AW:0]           ext, wide;

    assign s_ready   = !rst && (fifo_count < 2'd2);
    assign m_valid   = (fifo_count != 2'd0);
    assign m_data    = m_valid ? fifo_data[rd_ptr]  : '0;
    assign grp_beats = m_valid ? fifo_beats[rd_ptr] : '0;
    assign accept    = s_valid && s_ready;
    assign push      = accept && s_last;
    assign pop       = m_valid && m_ready;

    always_comb begin
        state_nxt = state;
        sum_vec   = '0;
        push_vec  = '0;
        base      = '0;
        sat       = '0;
        ext       = '0;
        wide      = '0;
        // A beat without an open group, or a first beat inside one, starts a fresh group.
        restart   = (state == IDLE) || s_first;
        proto_err = accept && ((state == IDLE) != s_first);
        cnt_nxt   = restart ? 16'd1 : ((cnt == 16'hFFFF) ? cnt : cnt + 16'd1);
        for (int unsigned j = 0; j < COLUMN; j++) begin
            base = restart ? '0 : acc[j*AW +: AW];
            ext  = {{(AW+1-OW){s_data[j*OW+OW-1]}}, s_data[j*OW +: OW]};
            wide = {base[AW-1], base} + ext;
            if (wide[AW] != wide[AW-1])
                sat = wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            else
                sat = wide[AW-1:0];
            sum_vec[j*AW +: AW]  = sat;
            push_vec[j*AW +: AW] = ((RELU != 0) && sat[AW-1]) ? '0 : sat;
        end
        if (accept)
            state_nxt = s_last ? IDLE : ACC;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            fifo_count <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data[i]  <= '0;
                fifo_beats[i] <= '0;
            end
        end else begin
            if (accept && !s_last) begin
                acc <= sum_vec;
                cnt <= cnt_nxt;
            end
            if (proto_err)
                err <= 1'b1;
            if (push) begin
                fifo_data[wr_ptr]  <= push_vec;
                fifo_beats[wr_ptr] <= cnt_nxt;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_acc.sv
// Scoreboard bench for mac_acc: randomized and directed groups against a plain
// arithmetic reference model; a monitor pops expected results as the DUT presents them.
module tb_mac_acc;

    localparam int COLUMN = 6;
    localparam int OW     = 22;
    localparam int AW     = 32;
    localparam int RELU   = 0;
    localparam longint MAXV = (longint'(1) << (AW-1)) - 1;
    localparam longint MINV = -(longint'(1) << (AW-1));
    localparam longint IMAX = (longint'(1) << (OW-1)) - 1;
    localparam longint IMIN = -(longint'(1) << (OW-1));

    logic                 clk, rst;
    logic [COLUMN*OW-1:0] s_data;
    logic                 s_first, s_last, s_valid, s_ready;
    logic [COLUMN*AW-1:0] m_data;
    logic                 m_valid, m_ready;
    logic [15:0]          grp_beats;
    logic                 err;

    mac_acc #(.COLUMN(COLUMN), .OW(OW), .AW(AW), .RELU(RELU)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_first(s_first), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .grp_beats(grp_beats), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [COLUMN*AW-1:0] data;
        logic [15:0]          beats;
    } exp_t;

    exp_t   exp_q[$];
    int     compared = 0;
    int     mismatched = 0;
    bit     hold_m = 0;
    bit     pop_one = 0;

    // reference model state
    longint bv[COLUMN];
    bit     md_open = 0;
    longint md_sum[COLUMN];
    int     md_cnt = 0;
    bit     md_err = 0;

    function automatic longint clamp(longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function void model_beat(bit first, bit last);
        exp_t e;
        longint v;
        if ((!md_open && !first) || (md_open && first))
            md_err = 1;
        if (!md_open || first) begin
            foreach (md_sum[j]) md_sum[j] = 0;
            md_cnt = 0;
        end
        foreach (md_sum[j]) md_sum[j] = clamp(md_sum[j] + bv[j]);
        md_cnt = (md_cnt < 65535) ? md_cnt + 1 : 65535;
        if (last) begin
            e.data = '0;
            for (int j = 0; j < COLUMN; j++) begin
                v = md_sum[j];
                if (RELU != 0 && v < 0) v = 0;
                e.data[j*AW +: AW] = AW'(v);
            end
            e.beats = 16'(md_cnt);
            exp_q.push_back(e);
            md_open = 0;
        end else begin
            md_open = 1;
        end
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic send(bit first, bit last);
        int  w = 0;
        bit  done = 0;
        while (!done) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_first = first;
            s_last  = last;
            for (int j = 0; j < COLUMN; j++) s_data[j*OW +: OW] = OW'(bv[j]);
            if (s_ready) begin
                model_beat(first, last);
                @(posedge clk);
                #1 s_valid = 1'b0;
                done = 1;
            end else if (++w > 200) begin
                compared++;
                mismatched++;
                $display("FAIL send_timeout: s_ready stuck at 0, expected 1");
                s_valid = 1'b0;
                done = 1;
            end
        end
    endtask

    task automatic drain();
        int w = 0;
        hold_m = 0;
        while ((exp_q.size() != 0 || m_valid) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", |m_data, 0);
        check("rst_grp_beats", grp_beats, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        md_open = 0;
        md_err = 0;
        exp_q.delete();
    endtask

    task automatic check_err(string name);
        @(negedge clk);
        check(name, err, md_err);
    endtask

    task automatic rand_lanes();
        logic [OW-1:0] r;
        for (int j = 0; j < COLUMN; j++) begin
            r = OW'($urandom);
            bv[j] = longint'($signed(r));
        end
    endtask

    task automatic fill_lanes(longint v);
        foreach (bv[j]) bv[j] = v;
    endtask

    // Monitor: drives m_ready, checks head stability under backpressure, pops on handshake.
    logic [COLUMN*AW-1:0] prev_d;
    logic [15:0]          prev_b;
    bit                   prev_hold = 0;
    exp_t                 got_e;
    initial begin
        forever begin
            @(negedge clk);
            if (prev_hold && !rst) begin
                compared++;
                if (m_data !== prev_d || grp_beats !== prev_b) begin
                    mismatched++;
                    $display("FAIL head_stable: got %0h/%0d expected %0h/%0d",
                             m_data, grp_beats, prev_d, prev_b);
                end
            end
            if (hold_m) begin
                m_ready = pop_one;
                pop_one = 0;
            end else begin
                m_ready = ($urandom_range(3) != 0);
            end
            prev_hold = m_valid && !m_ready && !rst;
            prev_d = m_data;
            prev_b = grp_beats;
            if (m_valid && m_ready && !rst) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_out: got %0h expected no result", m_data);
                end else begin
                    got_e = exp_q.pop_front();
                    if (m_data !== got_e.data || grp_beats !== got_e.beats) begin
                        mismatched++;
                        $display("FAIL result: got %0h beats %0d expected %0h beats %0d",
                                 m_data, grp_beats, got_e.data, got_e.beats);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        rst = 1'b1; s_valid = 0; s_first = 0; s_last = 0; s_data = '0; m_ready = 0;
        do_reset();

        // 3-beat group, lane j = {j, 10, -2}
        foreach (bv[j]) bv[j] = j;
        send(1, 0);
        fill_lanes(10);  send(0, 0);
        fill_lanes(-2);  send(0, 1);
        check_err("err_clean_group");

        // single-beat group with a negative lane
        rand_lanes(); bv[0] = -5;
        send(1, 1);

        // saturation at both rails
        for (int i = 0; i < 1100; i++) begin
            rand_lanes(); bv[0] = IMAX;
            send(i == 0, i == 1099);
        end
        for (int i = 0; i < 1100; i++) begin
            rand_lanes(); bv[0] = IMIN;
            send(i == 0, i == 1099);
        end
        drain();

        // backpressure: two results fill the FIFO, pop one frees input next cycle
        @(posedge clk); #1 hold_m = 1;
        rand_lanes(); send(1, 1);
        rand_lanes(); send(1, 1);
        @(negedge clk);
        check("full_s_ready", s_ready, 0);
        check("full_m_valid", m_valid, 1);
        @(posedge clk); #1 pop_one = 1;
        @(negedge clk);
        check("full_stall_on_pop", s_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("ready_after_pop", s_ready, 1);
        drain();

        // random groups with random output backpressure
        for (int g = 0; g < 40; g++) begin
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                rand_lanes();
                send(b == 0, b == len - 1);
            end
        end
        drain();

        // protocol errors: restart inside a group, then sticky err
        do_reset();
        fill_lanes(7); send(1, 0); send(0, 0);
        fill_lanes(3); send(1, 1);
        check_err("err_restart");
        rand_lanes(); send(1, 1);
        check_err("err_sticky");
        drain();

        // orphan beat without first
        do_reset();
        fill_lanes(9); send(0, 1);
        check_err("err_orphan");
        drain();

        // reset mid-group drops the partial sum
        do_reset();
        fill_lanes(5); send(1, 0); send(0, 0);
        do_reset();
        fill_lanes(4); send(1, 1);
        check_err("err_after_rst");
        drain();
        @(negedge clk);
        check("end_m_valid", m_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
